// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single-word reads for the PC address, captures
// the returned instruction, holds the PC while a fetch is outstanding.
module instr_fetch #(
  parameter logic [31:0] BOOT_ADDRESS   = 32'h0000_0000,
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        fetch_en,
  input  logic        dmem_busy,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        freeze_pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_fault
);

  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt;
  logic             misaligned_now;

  assign misaligned_now = (pc_addr[1:0] != 2'b00);

  // The request yields to data-memory traffic within the same cycle.
  assign bus_req   = (state == ISSUE) & ~dmem_busy;
  assign freeze_pc = (state != IDLE) | ~fetch_en | misaligned_now;
  assign bus_addr  = {addr_q[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      addr_q      <= BOOT_ADDRESS;
      cnt         <= '0;
      instr       <= RESET_INSTR;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      case (state)
        BOOT: begin
          addr_q <= BOOT_ADDRESS;
          cnt    <= '0;
          state  <= ISSUE;
        end
        IDLE: begin
          if (fetch_en) begin
            if (misaligned_now) begin
              instr       <= RESET_INSTR;
              instr_valid <= 1'b1;
              fetch_fault <= 1'b1;
            end else begin
              addr_q <= pc_addr;
              cnt    <= '0;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // Only granted cycles count; an ack on the limit cycle still wins.
          if (bus_req) begin
            if (bus_ack) begin
              instr       <= bus_rdata;
              instr_valid <= 1'b1;
              state       <= IDLE;
            end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
              instr       <= RESET_INSTR;
              instr_valid <= 1'b1;
              fetch_fault <= 1'b1;
              state       <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch unit directly downstream of the program counter. It takes the PC's next-instruction byte address, issues a single-word read on the shared memory bus, and captures the returned instruction into a register for decode. While a fetch is in flight it holds the PC frozen. Bus cycles yield to data-memory traffic, and faults are reported for misaligned or timed-out fetches.

Parameters:
BOOT_ADDRESS, 32'h0000_0000, byte address fetched automatically after reset.
RESET_INSTR, 32'h0000_0013, instruction substituted on reset or fault (NOP, addi x0,x0,0).
TIMEOUT_CYCLES, 64, number of granted-but-unacknowledged request cycles before a fault; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
pc_addr  input  32  next-instruction byte address from PC (base already added)
fetch_en  input  1  core has retired the current instruction and wants the next one
dmem_busy  input  1  data-memory access owns the bus this cycle
bus_ack  input  1  memory read complete; bus_rdata valid this cycle
bus_rdata  input  32  memory read data
bus_req  output  1  instruction read request
bus_addr  output  32  word-aligned read address (latched)
freeze_pc  output  1  PC hold; connects to the PC freeze input
instr  output  32  current instruction register
instr_valid  output  1  one-cycle pulse; instr was updated this cycle
fetch_fault  output  1  one-cycle pulse; misaligned or timed-out fetch

Behaviour:
- Reset (async, rst=1) forces the following immediately:
  - state=BOOT, bus_req=0, freeze_pc=1
  - instr=RESET_INSTR, instr_valid=0, fetch_fault=0
  - addr_q=BOOT_ADDRESS, timeout counter=0.
- Reset mid-fetch abandons the request. A late bus_ack is ignored unless the block is in ISSUE.
- States:
  - BOOT: lasts one cycle, then goes to ISSUE with addr_q=BOOT_ADDRESS.
  - IDLE: bus_req=0. If fetch_en=1:
    - pc_addr[1:0]==0: latch addr_q=pc_addr, counter=0, go to ISSUE.
    - pc_addr[1:0]!=0: do not issue on the bus. Next cycle instr=RESET_INSTR, instr_valid=1, fetch_fault=1. Stay in IDLE.
  - ISSUE: bus_req = ~dmem_busy, which is combinational and drops in the same cycle dmem_busy rises.
    - bus_ack is sampled at a clock edge only while bus_req=1. On ack: instr<=bus_rdata, instr_valid<=1, go to IDLE.
    - While bus_req=1 and bus_ack=0, the counter increments. Cycles with dmem_busy=1 do not count.
    - If the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES!=0): instr<=RESET_INSTR, instr_valid<=1, fetch_fault<=1, go to IDLE.
    - bus_ack while bus_req=0 is ignored.
- bus_addr = {addr_q[31:2],2'b00} in all states.
- freeze_pc = (state!=IDLE) | ~fetch_en | misaligned_now. The PC therefore advances exactly on the cycle a fetch is launched, so currentPc equals addr_q for the whole fetch.
- Latency:
  - Launch edge to bus_req high is 1 cycle.
  - Ack edge to instr/instr_valid is 1 cycle (registered).
  - Best-case throughput is one instruction per 2 cycles.
- In the cycle after an ack, state is IDLE and instr_valid=1. If fetch_en=1 in that same cycle, the next fetch launches immediately, so back-to-back fetches are legal.
- instr holds its value between updates. instr_valid and fetch_fault are never high for more than one consecutive cycle per event.
- Simultaneous ack and timeout limit in the same cycle: the ack wins and no fault is raised.
- pc_addr wrap from 32'hFFFF_FFFC to 0 is a normal fetch with no special handling.

Test Plan:
1. Reset release, memory acks 2 cycles after bus_req with rdata=32'h00500093 -> bus_addr=0, freeze_pc=1 throughout, instr=32'h00500093 with instr_valid pulse, then IDLE.
2. fetch_en=1, pc_addr=32'h0000_0004, ack after 1 cycle -> PC un-frozen for one cycle, bus_addr=4, instr captured, back-to-back launch at pc_addr=8 on the following cycle.
3. dmem_busy=1 for 5 cycles during ISSUE -> bus_req=0 for those cycles, counter frozen, fetch completes normally afterwards.
4. TIMEOUT_CYCLES=4, no ack -> after 4 granted cycles: fetch_fault pulse, instr=32'h00000013, state IDLE.
5. pc_addr=32'h0000_0006 with fetch_en=1 -> bus_req never asserts, next cycle fetch_fault=1, instr_valid=1, instr=NOP.
6. rst asserted mid-ISSUE, then bus_ack -> bus_req=0 immediately, ack ignored, instr=RESET_INSTR; after release, boot fetch from BOOT_ADDRESS.
